olivia_commit_monitor: RTL

- Synthesizable commit-stage checker for the Olivia LEGv8 core. It replaces the per-cycle bench printout with on-chip checking.
- Taps the core's commit signals and classifies each retired instruction by opcode[31:21].
- Keeps saturating per-class retire counters and independently recomputes ALU/address results.
- Pushes mismatches into a parametrised error FIFO, drained over a valid/ready port. Usable in simulation and in FPGA bring-up.

---
 rtl/olivia_commit_monitor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/olivia_commit_monitor.sv
// olivia_commit_monitor: commit-stage checker with per-class retire counters, ALU/address recompute and error FIFO.
// Define OLIVIA_MON_UNKNOWN_ERR_EN to also log every UNKNOWN-class commit as an error record.
module olivia_commit_monitor #(
  parameter int DATA_W = 64,
  parameter int PC_W = 64,
  parameter int CNT_W = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              commit_valid,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic [31:0]       commit_instr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] sign_ext,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_value,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [PC_W-1:0]   err_pc,
  output logic [31:0]       err_instr,
  output logic [DATA_W-1:0] err_expected,
  output logic [DATA_W-1:0] err_actual,
  output logic              err_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ, C_B, C_NOP, C_UNK} cls_t;
  cls_t cls, s1_cls;
  logic [10:0] op;
  assign op = commit_instr[31:21];
  always_comb
    cls = commit_instr == 32'h0 ? C_NOP :
          op == 11'b10001011000 ? C_ADD :
          op == 11'b11001011000 ? C_SUB :
          op == 11'b10001010000 ? C_AND :
          op == 11'b10101010000 ? C_ORR :
          op == 11'b11111000010 ? C_LDUR :
          op == 11'b11111000000 ? C_STUR :
          op == 11'b10110100000 ? C_CBZ :
          op == 11'b00010100000 ? C_B : C_UNK;
  // Slots 0-9 are classes, 10 is total; 11-15 never increment and read as 0.
  logic [CNT_W-1:0] cnt [16];
  assign cnt_value = cnt[cnt_sel];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
      cycle_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
      cycle_count <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (commit_valid && (i == int'(cls) || i == 10) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
    end
  logic s1_v;
  logic [PC_W-1:0] s1_pc;
  logic [31:0] s1_instr;
  logic [DATA_W-1:0] s1_a, s1_b, s1_imm, s1_res;
  always_ff @(posedge clk or negedge rst)
    if (!rst) s1_v <= 1'b0;
    else s1_v <= commit_valid && !clear;
  always_ff @(posedge clk)
    if (commit_valid) begin
      s1_pc <= commit_pc;
      s1_instr <= commit_instr;
      s1_cls <= cls;
      s1_a <= op_a;
      s1_b <= op_b;
      s1_imm <= sign_ext;
      s1_res <= alu_result;
    end
  logic [DATA_W-1:0] calc, exp_v, act_v;
  logic chk, push;
  assign calc = s1_cls == C_SUB ? s1_a - s1_b :
                s1_cls == C_AND ? s1_a & s1_b :
                s1_cls == C_ORR ? s1_a | s1_b :
                (s1_cls == C_LDUR || s1_cls == C_STUR) ? s1_a + s1_imm : s1_a + s1_b;
  assign chk = s1_v && s1_cls <= C_STUR && calc != s1_res;
`ifdef OLIVIA_MON_UNKNOWN_ERR_EN
  logic unk;
  assign unk = s1_v && s1_cls == C_UNK;
  assign exp_v = unk ? '0 : calc;
  assign act_v = unk ? {{(DATA_W-32){1'b0}}, s1_instr} : s1_res;
  assign push = chk || unk;
`else
  assign exp_v = calc;
  assign act_v = s1_res;
  assign push = chk;
`endif
  logic [AW:0] wr, rd;
  logic [PC_W-1:0] m_pc [FIFO_DEPTH];
  logic [31:0] m_instr [FIFO_DEPTH];
  logic [DATA_W-1:0] m_exp [FIFO_DEPTH], m_act [FIFO_DEPTH];
  logic full, pop, wr_en;
  assign err_valid = wr != rd;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign pop = err_valid && err_ready;
  assign wr_en = push && (!full || pop);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      err_overflow <= 1'b0;
    end else if (clear) begin
      wr <= '0;
      rd <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_en) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      if (push && full && !pop) err_overflow <= 1'b1;
    end
  // On full-with-pop the write lands in the slot being vacated; the head moves past it.
  always_ff @(posedge clk)
    if (wr_en) begin
      m_pc[wr[AW-1:0]] <= s1_pc;
      m_instr[wr[AW-1:0]] <= s1_instr;
      m_exp[wr[AW-1:0]] <= exp_v;
      m_act[wr[AW-1:0]] <= act_v;
    end
  assign err_pc = err_valid ? m_pc[rd[AW-1:0]] : '0;
  assign err_instr = err_valid ? m_instr[rd[AW-1:0]] : '0;
  assign err_expected = err_valid ? m_exp[rd[AW-1:0]] : '0;
  assign err_actual = err_valid ? m_act[rd[AW-1:0]] : '0;
endmodule
